mem_stage: RTL and testbench

- Pipeline stage between the execute stage and the writeback stage.
- Captures the execute-to-memory bus with the standard valid/allowin handshake.
- Waits for the data SRAM read response of loads, then aligns and extends sub-word load data.
- Drives forward/block information to decode and hands the final result to writeback.
- Buffers a response that arrives while writeback is stalled, so no returned data is lost.

---
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
// Ports: es_to_ms bus/handshake in, data SRAM response in, ms_to_ws bus out, fwd/blk bus to decode.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD   = 76,
  parameter int MS_TO_WS_BUS_WD   = 70,
  parameter int MS_FWD_BLK_BUS_WD = 39
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ws_allowin,
  output logic                         ms_allowin,
  input  logic                         es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  input  logic                         data_sram_data_ok,
  input  logic [31:0]                  data_sram_rdata,
  output logic                         ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_READY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_ms_valid;
  logic w_ms_valid_nxt;
  logic r_buf_valid;
  logic w_buf_valid_nxt;
  logic w_bus_ld;
  logic w_buf_ld;

  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic [31:0]                r_rdata_buf;

  logic [2:0]  w_ld_type;
  logic [1:0]  w_addr_lo;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_exe_result;
  logic [31:0] w_pc;

  assign w_ld_type      = r_es_bus[75:73];
  assign w_addr_lo      = r_es_bus[72:71];
  assign w_res_from_mem = r_es_bus[70];
  assign w_gr_we        = r_es_bus[69];
  assign w_dest         = r_es_bus[68:64];
  assign w_exe_result   = r_es_bus[63:32];
  assign w_pc           = r_es_bus[31:0];

  logic w_ms_ready_go;

  assign w_ms_ready_go  = (r_state == S_READY);
  assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;

  always_comb begin
    w_state_nxt     = r_state;
    w_ms_valid_nxt  = r_ms_valid;
    w_buf_valid_nxt = r_buf_valid;
    w_bus_ld        = 1'b0;
    w_buf_ld        = 1'b0;
    if (ms_allowin) begin
      // leaving (or idle): buffer belongs to the departing instr
      w_buf_valid_nxt = 1'b0;
      if (es_to_ms_valid) begin
        w_ms_valid_nxt = 1'b1;
        w_bus_ld       = 1'b1;
        w_state_nxt    = es_to_ms_bus[70] ? S_WAIT : S_READY;
      end else begin
        w_ms_valid_nxt = 1'b0;
        w_state_nxt    = S_EMPTY;
      end
    end else if (r_state == S_WAIT && data_sram_data_ok
                 && !r_buf_valid) begin
      w_buf_ld        = 1'b1;
      w_buf_valid_nxt = 1'b1;
      w_state_nxt     = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_EMPTY;
      r_ms_valid  <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ms_valid  <= w_ms_valid_nxt;
      r_buf_valid <= w_buf_valid_nxt;
    end
  end

  // payload needs no reset: it is qualified by r_ms_valid/r_state
  always_ff @(posedge clk) begin
    if (w_bus_ld) begin
      r_es_bus <= es_to_ms_bus;
    end
    if (w_buf_ld) begin
      r_rdata_buf <= data_sram_rdata;
    end
  end

  logic [31:0] w_byte_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic [31:0] w_final;

  assign w_byte_sh = r_rdata_buf >> {w_addr_lo, 3'b000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_addr_lo[1] ? r_rdata_buf[31:16]
                                  : r_rdata_buf[15:0];

  logic w_is_lb;
  logic w_is_lbu;
  logic w_is_lh;
  logic w_is_lhu;

  assign w_is_lb  = (w_ld_type == 3'd1);
  assign w_is_lbu = (w_ld_type == 3'd2);
  assign w_is_lh  = (w_ld_type == 3'd3);
  assign w_is_lhu = (w_ld_type == 3'd4);

  always_comb begin
    w_ld_data = r_rdata_buf;
    unique case (1'b1)
      w_is_lb:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      w_is_lbu: w_ld_data = {24'd0, w_byte};
      w_is_lh:  w_ld_data = {{16{w_half[15]}}, w_half};
      w_is_lhu: w_ld_data = {16'd0, w_half};
      default:  w_ld_data = r_rdata_buf;
    endcase
  end

  assign w_final = w_res_from_mem ? w_ld_data : w_exe_result;

  logic w_fwd_valid;
  logic w_blk_valid;

  assign w_fwd_valid = r_ms_valid && w_gr_we && (r_state == S_READY);
  assign w_blk_valid = r_ms_valid && (r_state == S_WAIT);

  assign ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
  assign ms_fwd_blk_bus = {w_fwd_valid, w_dest, w_final, w_blk_valid};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table + scoreboard bench for mem_stage.
// Hand sequences cover stall hold, back-to-back loads and reset in WAIT.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_fwd_blk_bus;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_blk_bus    (ms_fwd_blk_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_res;
  } vec_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic chk(string name, logic [69:0] act, logic [69:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 70'(1), 70'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ws_bus", ms_to_ws_bus, {e.gr_we, e.dest, e.result, e.pc});
        chk("fwd_bus", 70'(ms_fwd_blk_bus),
            70'({e.gr_we, e.dest, e.result, 1'b0}));
      end
    end
  end

  function automatic logic [75:0] mkbus(vec_t v, logic [31:0] pc);
    return {v.ld_type, v.addr_lo, v.rfm, v.gr_we, v.dest, v.exe, pc};
  endfunction

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;

    vt[0]  = '{3'd0, 2'd0, 1'b0, 1'b1, 5'd5,  32'h12345678, 32'h0,         0, 32'h12345678};
    vt[1]  = '{3'd1, 2'd3, 1'b1, 1'b1, 5'd6,  32'h00001003, 32'h80FF0011, 1, 32'hFFFFFF80};
    vt[2]  = '{3'd2, 2'd3, 1'b1, 1'b1, 5'd7,  32'h00001003, 32'h80FF0011, 1, 32'h00000080};
    vt[3]  = '{3'd3, 2'd2, 1'b1, 1'b1, 5'd8,  32'h00001002, 32'h80017FFF, 4, 32'hFFFF8001};
    vt[4]  = '{3'd4, 2'd2, 1'b1, 1'b1, 5'd9,  32'h00001002, 32'h80017FFF, 4, 32'h00008001};
    vt[5]  = '{3'd1, 2'd0, 1'b1, 1'b1, 5'd10, 32'h00001000, 32'h80FF0011, 1, 32'h00000011};
    vt[6]  = '{3'd1, 2'd2, 1'b1, 1'b1, 5'd11, 32'h00001002, 32'h80FF0011, 2, 32'hFFFFFFFF};
    vt[7]  = '{3'd3, 2'd1, 1'b1, 1'b1, 5'd12, 32'h00001001, 32'h80017FFF, 1, 32'h00007FFF};
    vt[8]  = '{3'd0, 2'd0, 1'b1, 1'b1, 5'd13, 32'h00001000, 32'hDEADBEEF, 2, 32'hDEADBEEF};
    vt[9]  = '{3'd6, 2'd1, 1'b1, 1'b1, 5'd14, 32'h00001001, 32'h01020304, 3, 32'h01020304};
    vt[10] = '{3'd0, 2'd0, 1'b0, 1'b0, 5'd0,  32'hA5A5A5A5, 32'h0,         0, 32'hA5A5A5A5};
    vt[11] = '{3'd2, 2'd1, 1'b1, 1'b1, 5'd15, 32'h00001001, 32'h0000FF00, 1, 32'h000000FF};

    step();
    step();
    @(negedge clk);
    chk("rst_allowin", 70'(ms_allowin), 70'(1));
    chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_fwdblk", 70'({ms_fwd_blk_bus[38], ms_fwd_blk_bus[0]}), 70'(0));
    step();
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      logic [31:0] pc;
      pc = 32'h1C000000 + 32'(i * 4);
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mkbus(vt[i], pc);
      sb.push_back('{vt[i].gr_we, vt[i].dest, vt[i].exp_res, pc});
      step();
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = 76'(64'($urandom) << 32) | 76'($urandom);
      for (int c = 1; c <= vt[i].delay; c++) begin
        if (c == vt[i].delay) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata = vt[i].rdata;
        end
        @(negedge clk);
        chk("wait_blk_allow_val",
            70'({ms_fwd_blk_bus[0], ms_allowin, ms_to_ws_valid}),
            70'(3'b100));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
      end
      @(negedge clk);
      chk("latency_valid", 70'(ms_to_ws_valid), 70'(1));
      step();
      @(negedge clk);
      chk("departed", 70'({ms_to_ws_valid, 31'(sb.size())}), 70'(0));
    end

    // completion under writeback stall
    begin
      vec_t v;
      logic [31:0] pc;
      v = '{3'd0, 2'd0, 1'b1, 1'b1, 5'd20, 32'h2000, 32'hCAFEBABE, 1, 32'hCAFEBABE};
      pc = 32'h1C001000;
      step();
      ws_allowin = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mkbus(v, pc);
      sb.push_back('{1'b1, 5'd20, 32'hCAFEBABE, pc});
      step();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hCAFEBABE;
      step();
      data_sram_data_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
        data_sram_rdata = 32'h11110000 + 32'(c);
        data_sram_data_ok = (c == 1);
        @(negedge clk);
        chk("hold_valid_allow", 70'({ms_to_ws_valid, ms_allowin}), 70'(2'b10));
        chk("hold_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFEBABE));
        step();
      end
      data_sram_data_ok = 1'b0;
      ws_allowin = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("hold_departed", 70'({ms_to_ws_valid, 31'(sb.size())}), 70'(0));
    end

    // back-to-back loads: B captured on A's departure edge
    begin
      vec_t a;
      vec_t b;
      a = '{3'd1, 2'd1, 1'b1, 1'b1, 5'd21, 32'h3001, 32'h00008000, 1, 32'hFFFFFF80};
      b = '{3'd4, 2'd0, 1'b1, 1'b1, 5'd22, 32'h3004, 32'h1234F00D, 2, 32'h0000F00D};
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mkbus(a, 32'h1C002000);
      sb.push_back('{1'b1, 5'd21, 32'hFFFFFF80, 32'h1C002000});
      step();
      es_to_ms_bus = mkbus(b, 32'h1C002004);
      sb.push_back('{1'b1, 5'd22, 32'h0000F00D, 32'h1C002004});
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h00008000;
      @(negedge clk);
      chk("b2b_a_wait", 70'({ms_fwd_blk_bus[0], ms_allowin}), 70'(2'b10));
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h1234F00D;
      step();
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      chk("b2b_b_wait", 70'({ms_fwd_blk_bus[0], ms_to_ws_valid}), 70'(2'b10));
      chk("b2b_b_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h1C002004));
      step();
      data_sram_data_ok = 1'b1;
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("b2b_done", 70'({ms_to_ws_valid, 31'(sb.size())}), 70'(0));
    end

    // reset in WAIT, then stray response
    begin
      vec_t v;
      v = '{3'd0, 2'd0, 1'b1, 1'b1, 5'd23, 32'h4000, 32'h0, 0, 32'h0};
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mkbus(v, 32'h1C003000);
      step();
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_blk", 70'(ms_fwd_blk_bus[0]), 70'(1));
      step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hBAD0BAD0;
      step();
      data_sram_data_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("post_rst_state",
            70'({ms_to_ws_valid, ms_allowin, ms_fwd_blk_bus[38],
                 ms_fwd_blk_bus[0]}),
            70'(4'b0100));
        step();
      end
      chk("sb_empty", 70'(sb.size()), 70'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
